// File: rtl/icg_enable_sequencer_if.sv
// Branch request / ICG enable bundle between the clock requesters and the sequencer.
interface icg_enable_sequencer_if #(
  parameter int unsigned N = 4
);
  logic [N-1:0] REQ;
  logic [N-1:0] EN;
  logic [N-1:0] ACK;
  logic         BUSY;

  modport master (output REQ, input EN, input ACK, input BUSY);
  modport slave  (input REQ, output EN, output ACK, output BUSY);
endinterface

// File: rtl/icg_enable_sequencer.sv
// Per-branch ICG enable sequencer: idle hysteresis plus round-robin staggered turn-on.
module icg_enable_sequencer #(
  parameter int unsigned N       = 4,
  parameter int unsigned IDLE_W  = 8,
  parameter int unsigned STAGGER = 2
) (
  input  logic              CLK,
  input  logic              RN,
  input  logic [IDLE_W-1:0] IDLE,
  input  logic              TM,
  icg_enable_sequencer_if.slave bus
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SW = 4;

  typedef enum logic [1:0] {ST_OFF, ST_WAIT, ST_ON, ST_HOLD} state_e;

  state_e            state_q [N];
  state_e            state_d [N];
  logic [IDLE_W-1:0] cnt_q   [N];
  logic [IDLE_W-1:0] cnt_d   [N];
  logic [SW-1:0]     s_q, s_d;
  logic [PW-1:0]     p_q, p_d;
  logic [N-1:0]      en_q, en_d;
  logic [N-1:0]      ack_q, ack_d;
  logic              busy_q, busy_d;

  logic              grant_vld;
  logic [PW-1:0]     grant_idx;
  logic [N-1:0]      grant_vec;
  int unsigned       idx;

  // State, counter, arbiter and output registers
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      for (int i = 0; i < int'(N); i++) begin
        state_q[i] <= ST_OFF;
        cnt_q[i]   <= '0;
      end
      s_q    <= '0;
      p_q    <= '0;
      en_q   <= '0;
      ack_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      for (int i = 0; i < int'(N); i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      s_q    <= s_d;
      p_q    <= p_d;
      en_q   <= en_d;
      ack_q  <= ack_d;
      busy_q <= busy_d;
    end
  end

  // Arbitration and per-branch next state; a grant needs the request still high
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    grant_vec = '0;
    idx       = 0;
    s_d       = s_q;
    p_d       = p_q;

    if (s_q != '0) begin
      s_d = s_q - SW'(1);
    end else begin
      for (int unsigned off = 0; off < N; off++) begin
        idx = (32'(p_q) + off) % N;
        if (!grant_vld && state_q[idx] == ST_WAIT && bus.REQ[idx]) begin
          grant_vld = 1'b1;
          grant_idx = PW'(idx);
        end
      end
    end

    if (grant_vld) begin
      grant_vec[grant_idx] = 1'b1;
      s_d = SW'(STAGGER);
      p_d = PW'((32'(grant_idx) + 32'd1) % N);
    end

    for (int i = 0; i < int'(N); i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_OFF: begin
          if (bus.REQ[i]) state_d[i] = ST_WAIT;
        end
        ST_WAIT: begin
          if (!bus.REQ[i])      state_d[i] = ST_OFF;
          else if (grant_vec[i]) state_d[i] = ST_ON;
        end
        ST_ON: begin
          if (!bus.REQ[i]) begin
            if (IDLE == '0) begin
              state_d[i] = ST_OFF;
            end else begin
              state_d[i] = ST_HOLD;
              cnt_d[i]   = IDLE;
            end
          end
        end
        ST_HOLD: begin
          if (bus.REQ[i]) begin
            state_d[i] = ST_ON;
          end else if (cnt_q[i] == IDLE_W'(1)) begin
            state_d[i] = ST_OFF;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] - IDLE_W'(1);
          end
        end
        default: state_d[i] = ST_OFF;
      endcase
    end
  end

  // Registered outputs derived from next state; ACK trails EN but drops with it
  always_comb begin
    en_d   = '0;
    busy_d = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      en_d[i] = (state_d[i] == ST_ON) || (state_d[i] == ST_HOLD);
      busy_d  = busy_d | (state_d[i] != ST_OFF);
    end
    ack_d = en_q & en_d;
  end

  assign bus.EN   = en_q | {N{TM}};
  assign bus.ACK  = ack_q;
  assign bus.BUSY = busy_q;

endmodule
